// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit unsigned adder: one full-add cell and a carry flop,
// time-shared across all bit positions, LSB first.

module serial_add_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, r_sh;
  logic             carry;
  logic [CW-1:0]    count;
  logic             s, c, last, accept;

  serial_add_cell u_cell (
    .a (a_sh[0]),
    .b (b_sh[0]),
    .ci(carry),
    .s (s),
    .co(c)
  );

  assign last   = (count == CW'(WIDTH - 1));
  assign accept = start && (state == IDLE || state == DONE);
  assign busy   = (state == SHIFT);
  assign done   = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:    state_nxt = start ? SHIFT : IDLE;
      SHIFT:   state_nxt = last  ? DONE  : SHIFT;
      DONE:    state_nxt = start ? SHIFT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The last sum bit is folded into the result on the completion edge so
  // sum/carry_out only move once per operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh      <= '0;
      b_sh      <= '0;
      r_sh      <= '0;
      carry     <= 1'b0;
      count     <= '0;
      sum       <= '0;
      carry_out <= 1'b0;
    end else if (accept) begin
      a_sh  <= a;
      b_sh  <= b;
      carry <= 1'b0;
      count <= '0;
    end else if (state == SHIFT) begin
      a_sh  <= a_sh >> 1;
      b_sh  <= b_sh >> 1;
      r_sh  <= {s, r_sh[WIDTH-1:1]};
      carry <= c;
      count <= count + 1'b1;
      if (last) begin
        sum       <= {s, r_sh[WIDTH-1:1]};
        carry_out <= c;
      end
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: WIDTH=8 and WIDTH=4 instances, directed cases plus
// random/exhaustive operands checked against plain a+b arithmetic.

module tb_serial_adder;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start8 = 1'b0, start4 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0, sum8;
  logic [3:0] a4 = '0, b4 = '0, sum4;
  logic       busy8, done8, co8, busy4, done4, co4;
  int         checks = 0, passed = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .sum(sum8), .carry_out(co8)
  );

  serial_adder #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .sum(sum4), .carry_out(co4)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int w, input logic s, input logic [31:0] x, input logic [31:0] y);
    if (w == 8) begin start8 = s; a8 = x[7:0]; b8 = y[7:0]; end
    else        begin start4 = s; a4 = x[3:0]; b4 = y[3:0]; end
  endtask

  function automatic logic f_busy(input int w);
    return (w == 8) ? busy8 : busy4;
  endfunction
  function automatic logic f_done(input int w);
    return (w == 8) ? done8 : done4;
  endfunction
  function automatic logic [31:0] f_sum(input int w);
    return (w == 8) ? {24'd0, sum8} : {28'd0, sum4};
  endfunction
  function automatic logic f_co(input int w);
    return (w == 8) ? co8 : co4;
  endfunction

  // One single-cycle-start operation: checks latency, busy, output hold and result.
  task automatic op(input int w, input logic [31:0] xi, input logic [31:0] yi);
    logic [32:0] mask, x, y, ref_val;
    logic [31:0] prev;
    int          lat;
    bit          hold_ok, busy_ok, got;
    mask    = (33'd1 << w) - 33'd1;
    x       = {1'b0, xi} & mask;
    y       = {1'b0, yi} & mask;
    ref_val = x + y;
    prev    = f_sum(w);
    drive(w, 1'b1, x[31:0], y[31:0]);
    tick();
    drive(w, 1'b0, $urandom, $urandom);
    chk("busy_after_accept", f_busy(w), 1);
    hold_ok = 1; busy_ok = 1; lat = -1; got = 0;
    for (int n = 1; n <= w + 4 && !got; n++) begin
      tick();
      if (f_done(w)) begin
        lat = n;
        got = 1;
      end else begin
        if (!f_busy(w)) busy_ok = 0;
        if (f_sum(w) !== prev) hold_ok = 0;
      end
    end
    chk("latency", lat, w);
    chk("busy_during_shift", busy_ok, 1);
    chk("sum_hold", hold_ok, 1);
    chk("busy_at_done", f_busy(w), 0);
    chk("sum", f_sum(w), ref_val & mask);
    chk("carry_out", f_co(w), ref_val >> w);
    tick();
    chk("done_one_cycle", f_done(w), 0);
  endtask

  initial begin
    int       pulses, lat;
    logic [7:0] seen_sum;
    logic       seen_co;
    bit         saw_done;

    // Reset state
    #3;
    chk("rst_busy8", busy8, 0);
    chk("rst_done8", done8, 0);
    chk("rst_sum8", sum8, 0);
    chk("rst_co8", co8, 0);
    chk("rst_sum4", sum4, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Directed basics
    op(8, 100, 27);
    op(8, 255, 1);
    op(8, 200, 100);

    // start pulsed mid-operation is ignored
    drive(8, 1'b1, 10, 5);
    tick();
    drive(8, 1'b0, 0, 0);
    tick(); tick();
    drive(8, 1'b1, 1, 1);
    tick();
    drive(8, 1'b0, 0, 0);
    pulses = 0; seen_sum = '0; seen_co = 1'b1;
    for (int n = 0; n < 14; n++) begin
      tick();
      if (done8) begin
        pulses++;
        seen_sum = sum8;
        seen_co  = co8;
      end
    end
    chk("ignore_pulses", pulses, 1);
    chk("ignore_sum", seen_sum, 15);
    chk("ignore_co", seen_co, 0);

    // start held high: back-to-back operations
    drive(8, 1'b1, 3, 4);
    tick();
    chk("b2b_busy0", busy8, 1);
    lat = -1;
    for (int n = 1; n <= 12 && lat < 0; n++) begin
      tick();
      if (done8) lat = n;
    end
    chk("b2b_lat0", lat, 8);
    chk("b2b_sum0", sum8, 7);
    drive(8, 1'b1, 0, 0);
    tick();
    chk("b2b_rebusy", busy8, 1);
    chk("b2b_nodone", done8, 0);
    lat = -1;
    for (int n = 2; n <= 14 && lat < 0; n++) begin
      tick();
      if (done8) lat = n;
    end
    chk("b2b_gap", lat, 9);
    chk("b2b_sum1", sum8, 0);
    chk("b2b_co1", co8, 0);
    drive(8, 1'b0, 0, 0);
    tick();
    chk("b2b_idle_busy", busy8, 0);
    chk("b2b_idle_done", done8, 0);

    // Reset mid-operation
    op(8, 200, 100);
    drive(8, 1'b1, 255, 255);
    tick();
    drive(8, 1'b0, 0, 0);
    tick(); tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy8, 0);
    chk("mid_rst_done", done8, 0);
    chk("mid_rst_sum", sum8, 0);
    chk("mid_rst_co", co8, 0);
    tick();
    rst_n = 1'b1;
    saw_done = 0;
    for (int n = 0; n < 12; n++) begin
      tick();
      if (done8 || busy8) saw_done = 1;
    end
    chk("post_rst_quiet", saw_done, 0);
    op(8, 1, 2);

    // Random WIDTH=8
    repeat (40) op(8, $urandom, $urandom);

    // Exhaustive WIDTH=4
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        op(4, i, j);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
